// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: drives a variable-latency req/ack data memory and stalls the pipe meanwhile.
// Optional watchdog abort is built when MEM_STAGE_CTRL_TIMEOUT_EN is defined.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData_out,
    output logic        stall,
    output logic        wb_bubble,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        w_mem_op;
    logic        w_issue;
    logic        w_ack_done;
    logic        w_timeout;
    logic        w_stall;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;

    assign w_mem_op = op_valid & (MemRead_in | MemWrite_in);

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_timeout_err;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Abort on the last allowed WAIT cycle; a simultaneous ack takes priority.
    assign w_timeout = (r_state == StWait) & ~mem_ack & (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cnt <= '0;
            end else if ((r_state == StWait) && !mem_ack) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
    assign w_timeout    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_ack_done   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_mem_op) begin
                    w_state_next = StWait;
                    w_issue      = 1'b1;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    w_state_next = StDone;
                    w_ack_done   = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = StDone;
                end
            end
            // The instruction is still in EX/MEM here; ignoring inputs prevents a reissue.
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_mem_req <= (w_state_next == StWait);
            if (w_issue) begin
                r_mem_addr  <= Addr;
                r_mem_wdata <= WriteData;
                r_mem_we    <= MemWrite_in;
            end
            if (w_ack_done && !r_mem_we) begin
                r_rdata <= mem_rdata;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

    // Gated by rst_n so a held op_valid cannot stall the pipe during reset.
    assign w_stall = rst_n & (((r_state == StIdle) & w_mem_op) | (r_state == StWait));

    assign stall        = w_stall;
    assign wb_bubble    = w_stall;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign ReadData_out = r_rdata;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the 5-stage pipeline. Drives a variable-latency data-memory request/acknowledge interface for loads and stores, freezes the upstream pipeline while an access is outstanding, and forces bubbles into the MEM/WB register so a stalled instruction writes back exactly once. Its `ReadData_out` feeds the MEM/WB register's `ReadData` input.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum WAIT cycles before abort (only with the timeout feature).
- `CNT_W`, default 5: wait-counter width; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op_valid` in 1: EX/MEM holds a valid instruction.
- `MemRead_in` in 1: load.
- `MemWrite_in` in 1: store.
- `Addr` in 32: memory address, the ALU result from EX/MEM.
- `WriteData` in 32: store data.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 means write.
- `mem_addr` out 32: registered address.
- `mem_wdata` out 32: registered store data.
- `mem_ack` in 1: memory completion, sampled in WAIT only.
- `mem_rdata` in 32: load data, valid with `mem_ack`.
- `ReadData_out` out 32: held load data to MEM/WB.
- `stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `wb_bubble` out 1: force `RegWrite`/`MemToReg` to 0 into MEM/WB.
- `timeout_err` out 1: sticky abort flag.

## Operation
- States: IDLE, WAIT, DONE (2-bit, registered).
- `mem_op = op_valid & (MemRead_in | MemWrite_in)`. If both read and write are set, the op is a write.

Transitions:
- IDLE → WAIT on `mem_op`. On that edge, latch `mem_addr <= Addr`, `mem_wdata <= WriteData`, `mem_we <= MemWrite_in`; clear the counter.
- WAIT → DONE when `mem_ack` is sampled high. For a read, `ReadData_out <= mem_rdata` on that edge; for a write, `ReadData_out` is unchanged.
- DONE → IDLE unconditionally. Inputs are ignored in DONE, so the same instruction, still sitting in EX/MEM, is not reissued.

Outputs:
- `mem_req` is registered: 1 in WAIT, 0 otherwise.
- `stall = (state==IDLE & mem_op) | (state==WAIT)`. This is combinational.
- `wb_bubble = stall`.
- Non-memory ops and `op_valid=0` in IDLE: no stall, no request, `ReadData_out` held.
- `mem_ack` in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `ReadData_out` 0, `timeout_err` 0, counter 0.
- `stall` and `wb_bubble` are 0 while `rst_n` is low (`op_valid` is forced to be ignored).
- Access sequence, with the op first seen in IDLE at cycle T and ack sampled k cycles after `mem_req` rises (k≥0):
  - `mem_req` is high over T+1..T+1+k.
  - DONE occurs at T+2+k.
  - `stall` is high over T..T+1+k, i.e. k+2 cycles.
  - MEM/WB captures the instruction with valid `ReadData_out` at the DONE edge.
- Back-to-back memory ops: the second is seen in IDLE at T+3+k. The minimum issue interval is 3 cycles.
- Reset asserted mid-WAIT: immediate return to IDLE and `mem_req` drops asynchronously. A late `mem_ack` after reset is ignored.

## Configuration
- `MEM_STAGE_CTRL_TIMEOUT_EN` defined:
  - The counter increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: transition to DONE, `mem_req` drops, `ReadData_out <= 0`, `timeout_err <= 1` (sticky until reset).
  - Ack on the same cycle as the timeout wins (normal completion).
- Not defined: no counter; WAIT persists until ack; `timeout_err` is tied 0.

## Test plan
- Reset then a non-memory op (`op_valid=1`, `MemRead_in=0`, `MemWrite_in=0`) → `stall=0`, `mem_req=0`, `ReadData_out=0`.
- Load at `Addr=0x40`, ack with `mem_rdata=0x1234_5678` after k=3 → `stall` high 5 cycles, `mem_req` high 4 cycles, `mem_addr=0x40`, `mem_we=0`, `ReadData_out=0x1234_5678` at DONE.
- Store at `Addr=0x80`, `WriteData=0xCAFE_F00D`, ack with k=0 → `mem_we=1`, `mem_wdata=0xCAFE_F00D`, 2 stall cycles, `ReadData_out` unchanged.
- Two loads back-to-back, both k=1 → second `mem_req` rises exactly 4 cycles after the first; each instruction gets `wb_bubble=0` exactly once.
- Drop `rst_n` during WAIT at k=2 → `mem_req=0` and state IDLE immediately; an ack one cycle later has no effect.
- With `MEM_STAGE_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`, no ack → DONE after 16 WAIT cycles, `timeout_err=1` and held, `ReadData_out=0`.
